// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants, arbiter state encoding and a
//               rotating-priority select helper used by bus arbiters.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int BAUD_9600   = 1250;  // clk cycles per bit at 9600 baud
    localparam int UART_DATA_W = 8;
    localparam int RR_MAX_N    = 8;     // widest requester vector rr_select handles

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

    // One-hot of the first set bit of req, searching from (ptr+1) upward and
    // wrapping at n. Only the low n bits of req are considered.
    function automatic logic [RR_MAX_N-1:0] rr_select(
        input logic [RR_MAX_N-1:0] req,
        input int                  ptr,
        input int                  n
    );
        logic [RR_MAX_N-1:0] sel;
        logic                found;
        int                  j;
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= RR_MAX_N; k++) begin
            // ptr < n and k <= n, so a single subtraction performs the wrap
            j = ptr + k;
            if (j >= n) begin
                j = j - n;
            end
            if ((k <= n) && !found && req[j[2:0]]) begin
                sel[j[2:0]] = 1'b1;
                found       = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotating-priority encoder. The search starts
//               one position above i_ptr and wraps, so the last winner gets
//               lowest priority next time.
//   i_req    : request vector
//   i_ptr    : index of the previous winner
//   o_onehot : one-hot winner (zero when no request)
//   o_idx    : binary index of the winner
//   o_any    : at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_onehot,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_any
);

    logic [RR_MAX_N-1:0] w_req_ext;
    logic [RR_MAX_N-1:0] w_sel;

    always_comb begin
        w_req_ext              = '0;
        w_req_ext[N_REQ-1:0]   = i_req;
        w_sel                  = rr_select(w_req_ext, int'(i_ptr), N_REQ);
    end

    assign o_onehot = w_sel[N_REQ-1:0];
    assign o_any    = |w_sel;

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (o_onehot[i]) begin
                o_idx = PTR_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Packet-granular round-robin arbiter sharing one UART TX
//               serializer between N_REQ byte-stream requesters. The grant is
//               held until the owner transfers a byte flagged last, or until
//               the owner leaves valid low for TIMEOUT cycles.
//   clk, rst          : clock, asynchronous active-high reset
//   i_req_valid/data/last, o_req_ready : per-requester byte streams
//   o_tx_valid/data, i_tx_ready        : serializer byte interface
//   o_grant           : one-hot current owner, zero when idle
//   o_timeout         : one-cycle pulse when the watchdog reclaims the channel
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = UART_DATA_W,
    parameter int TIMEOUT = 12500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ*DATA_W-1:0] i_req_data,
    input  logic [N_REQ-1:0]        i_req_last,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic                    o_tx_valid,
    output logic [DATA_W-1:0]       o_tx_data,
    input  logic                    i_tx_ready,
    output logic [N_REQ-1:0]        o_grant,
    output logic                    o_timeout
);

    localparam int               PTR_W      = $clog2(N_REQ);
    localparam int               CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] C_PTR_RST  = PTR_W'(N_REQ - 1);

    arb_state_t       r_state;
    logic [N_REQ-1:0] r_grant;
    logic [PTR_W-1:0] r_gidx;     // binary copy of r_grant for the muxes
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    logic [N_REQ-1:0] w_pick;
    logic [PTR_W-1:0] w_pick_idx;
    logic             w_any;
    logic             w_own_valid;
    logic             w_own_last;
    logic [DATA_W-1:0] w_data [N_REQ];

    genvar gk;
    generate
        for (gk = 0; gk < N_REQ; gk++) begin : g_slice
            assign w_data[gk] = i_req_data[gk*DATA_W +: DATA_W];
        end
    endgenerate

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .i_req    (i_req_valid),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick),
        .o_idx    (w_pick_idx),
        .o_any    (w_any)
    );

    assign w_own_valid = i_req_valid[r_gidx];
    assign w_own_last  = i_req_last[r_gidx];

    // Pass-through datapath driven from the registered grant; nothing is
    // buffered so the arbiter never holds a byte of its own.
    always_comb begin
        o_tx_valid  = 1'b0;
        o_tx_data   = '0;
        o_req_ready = '0;
        if (r_state == ARB_OWN) begin
            o_tx_valid          = w_own_valid;
            o_tx_data           = w_data[r_gidx];
            o_req_ready[r_gidx] = i_tx_ready;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ARB_IDLE;
            r_grant   <= '0;
            r_gidx    <= '0;
            r_ptr     <= C_PTR_RST;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_gidx  <= w_pick_idx;
                        r_cnt   <= '0;
                        r_state <= ARB_OWN;
                    end
                end
                ARB_OWN: begin
                    if (w_own_valid) begin
                        // Any presented byte, stalled or not, feeds the watchdog
                        r_cnt <= '0;
                        if (i_tx_ready && w_own_last) begin
                            r_ptr   <= r_gidx;
                            r_grant <= '0;
                            r_state <= ARB_IDLE;
                        end
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_ptr     <= r_gidx;
                        r_grant   <= '0;
                        r_cnt     <= '0;
                        r_timeout <= 1'b1;
                        r_state   <= ARB_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign o_grant   = r_grant;
    assign o_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Scoreboard bench for uart_tx_arbiter. Stimulus code pushes the
//               expected (requester, byte, last) sequence; a negedge monitor
//               pops and compares on every accepted byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N_REQ   = 4;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 12500;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        i_req_valid;
    logic [N_REQ*DATA_W-1:0] i_req_data;
    logic [N_REQ-1:0]        i_req_last;
    logic [N_REQ-1:0]        o_req_ready;
    logic                    o_tx_valid;
    logic [DATA_W-1:0]       o_tx_data;
    logic                    i_tx_ready;
    logic [N_REQ-1:0]        o_grant;
    logic                    o_timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ   (N_REQ),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .i_req_last  (i_req_last),
        .o_req_ready (o_req_ready),
        .o_tx_valid  (o_tx_valid),
        .o_tx_data   (o_tx_data),
        .i_tx_ready  (i_tx_ready),
        .o_grant     (o_grant),
        .o_timeout   (o_timeout)
    );

    typedef struct packed {logic [7:0] data; logic last;} byte_t;
    typedef struct packed {logic [1:0] idx; logic [7:0] data; logic last;} exp_t;

    byte_t            src_q [N_REQ][$];
    exp_t             exp_q [$];
    int               gap [N_REQ];
    bit               noise_en [N_REQ];
    bit               gaps_on;
    int               rdy_mode;     // 0: ready high, 1: random, 2: ready low
    int               compared   = 0;
    int               mismatched = 0;
    int               timeout_pulses = 0;
    int               mptr;         // reference-model rotation pointer
    logic [N_REQ-1:0] last_grant, last_ready;
    logic             last_timeout, last_txvalid;
    logic [7:0]       last_txdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: structural invariants every cycle, scoreboard on each transfer
    always @(negedge clk) begin : mon
        exp_t       e;
        logic [1:0] a_idx;
        if (rst === 1'b0) begin
            check("grant_onehot0", 32'($onehot0(o_grant)), 32'd1);
            check("ready_only_owner", 32'(o_req_ready & ~o_grant), 32'd0);
            if (o_timeout) timeout_pulses++;
            if (o_tx_valid && i_tx_ready) begin
                a_idx = 2'd0;
                for (int k = 0; k < N_REQ; k++) if (o_grant[k]) a_idx = 2'(k);
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_byte: got req%0d data 0x%02h, required no transfer",
                             a_idx, o_tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte{idx,data,last}", 32'({a_idx, o_tx_data, i_req_last[a_idx]}),
                          32'({e.idx, e.data, e.last}));
                end
            end
        end
    end

    task automatic drive_inputs();
        for (int k = 0; k < N_REQ; k++) begin
            if (noise_en[k] && src_q[0].size() > 1) begin
                i_req_valid[k]                = 1'($urandom_range(0, 1));
                i_req_data[k*DATA_W +: DATA_W] = 8'hFF;
                i_req_last[k]                 = 1'($urandom_range(0, 1));
            end else if (src_q[k].size() > 0 && gap[k] == 0) begin
                i_req_valid[k]                = 1'b1;
                i_req_data[k*DATA_W +: DATA_W] = src_q[k][0].data;
                i_req_last[k]                 = src_q[k][0].last;
            end else begin
                i_req_valid[k]                = 1'b0;
                i_req_data[k*DATA_W +: DATA_W] = 8'($urandom);
                i_req_last[k]                 = 1'($urandom);
            end
        end
        case (rdy_mode)
            0:       i_tx_ready = 1'b1;
            1:       i_tx_ready = ($urandom_range(0, 3) != 0);
            default: i_tx_ready = 1'b0;
        endcase
    endtask

    // One clock: sample outputs mid-cycle, retire accepted bytes, redrive.
    task automatic step();
        logic [N_REQ-1:0] fire;
        byte_t            b;
        @(negedge clk);
        fire         = o_req_ready & i_req_valid;
        last_grant   = o_grant;
        last_ready   = o_req_ready;
        last_timeout = o_timeout;
        last_txdata  = o_tx_data;
        last_txvalid = o_tx_valid;
        @(posedge clk);
        #1;
        for (int k = 0; k < N_REQ; k++) begin
            if (gap[k] > 0) gap[k]--;
            if (fire[k] && src_q[k].size() > 0) begin
                b = src_q[k].pop_front();
                if (gaps_on && !b.last && $urandom_range(0, 3) == 0) gap[k] = int'($urandom_range(1, 3));
            end
        end
        drive_inputs();
    endtask

    function automatic bit srcs_empty();
        bit e;
        e = 1'b1;
        for (int k = 0; k < N_REQ; k++) if (src_q[k].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < N_REQ; k++) begin
            src_q[k].delete();
            gap[k]      = 0;
            noise_en[k] = 1'b0;
        end
        exp_q.delete();
        mptr = N_REQ - 1;
        drive_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_until_empty(input string name, input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && srcs_empty()) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            compared++;
            mismatched++;
            $display("FAIL %s_drain: %0d bytes outstanding, required 0", name, exp_q.size());
        end
        repeat (3) step();
    endtask

    task automatic push_pkt(input int k, input logic [7:0] d, input logic last);
        src_q[k].push_back('{d, last});
        exp_q.push_back('{2'(k), d, last});
    endtask

    // Reference model: whole packets served in rotation starting after the
    // last served requester, skipping requesters with nothing left.
    task automatic model_round();
        byte_t mq [N_REQ][$];
        byte_t b;
        bit    any;
        int    j;
        for (int k = 0; k < N_REQ; k++) mq[k] = src_q[k];
        do begin
            any = 1'b0;
            for (int i = 1; i <= N_REQ; i++) begin
                j = (mptr + i) % N_REQ;
                if (mq[j].size() > 0) begin
                    do begin
                        b = mq[j].pop_front();
                        exp_q.push_back('{2'(j), b.data, b.last});
                    end while (!b.last);
                    mptr = j;
                    any  = 1'b1;
                    break;
                end
            end
        end while (any);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int n, bad, tp0, len, npk;
        rst = 1'b1; i_req_valid = '0; i_req_data = '0; i_req_last = '0; i_tx_ready = 1'b0;
        rdy_mode = 0; gaps_on = 1'b0;
        do_reset();

        // Reset / idle state
        step();
        check("reset_grant", 32'(last_grant), 32'd0);
        check("reset_tx_valid", 32'(last_txvalid), 32'd0);
        check("reset_tx_data", 32'(last_txdata), 32'd0);
        check("reset_ready", 32'(last_ready), 32'd0);
        check("reset_timeout", 32'(last_timeout), 32'd0);

        // Single requester, two-byte packet
        push_pkt(1, 8'h61, 1'b0);
        push_pkt(1, 8'h62, 1'b1);
        drive_inputs();
        step(); check("single_arb_cycle_grant", 32'(last_grant), 32'b0000);
        step(); check("single_grant", 32'(last_grant), 32'b0010);
                check("single_byte0", 32'(last_txdata), 32'h61);
        step(); check("single_byte1", 32'(last_txdata), 32'h62);
        step(); check("single_release_grant", 32'(last_grant), 32'b0000);
        run_until_empty("single", 20);

        // Contention after reset: 0, 2, 3 and again after wrap
        do_reset();
        push_pkt(0, 8'hA0, 1'b1); push_pkt(2, 8'hA2, 1'b1); push_pkt(3, 8'hA3, 1'b1);
        drive_inputs();
        run_until_empty("contention1", 50);
        push_pkt(0, 8'hB0, 1'b1); push_pkt(2, 8'hB2, 1'b1); push_pkt(3, 8'hB3, 1'b1);
        drive_inputs();
        run_until_empty("contention2", 50);

        // Long backpressure never trips the watchdog
        rdy_mode = 2;
        push_pkt(2, 8'h41, 1'b1);
        drive_inputs();
        n = 0;
        do begin step(); n++; end while (last_grant != 4'b0100 && n < 10);
        check("bp_grant", 32'(last_grant), 32'b0100);
        tp0 = timeout_pulses; bad = 0;
        repeat (5000) begin
            step();
            if (last_txdata != 8'h41 || last_ready[2] != 1'b0 || !last_txvalid) bad++;
        end
        check("bp_hold_bad_cycles", 32'(bad), 32'd0);
        check("bp_no_timeout", 32'(timeout_pulses - tp0), 32'd0);
        rdy_mode = 0;
        step(); step();
        check("bp_accept_first_ready", 32'(exp_q.size()), 32'd0);
        run_until_empty("bp", 10);

        // Watchdog release
        do_reset();
        push_pkt(1, 8'h10, 1'b0);
        drive_inputs();
        n = 0;
        do begin step(); n++; end while (src_q[1].size() != 0 && n < 10);
        push_pkt(2, 8'h20, 1'b1);
        drive_inputs();
        n = 0;
        do begin step(); n++; end while (!last_timeout && n < TIMEOUT + 10);
        check("timeout_latency", 32'(n), 32'(TIMEOUT + 1));
        check("timeout_grant_cleared", 32'(last_grant), 32'd0);
        step();
        check("timeout_pulse_width", 32'(last_timeout), 32'd0);
        check("timeout_next_grant", 32'(last_grant), 32'b0100);
        run_until_empty("timeout", 20);

        // Asynchronous reset mid-packet
        do_reset();
        push_pkt(3, 8'h30, 1'b0);
        src_q[3].push_back('{8'h31, 1'b0});
        src_q[3].push_back('{8'h32, 1'b1});
        drive_inputs();
        n = 0;
        do begin step(); n++; end while (src_q[3].size() != 2 && n < 10);
        #2 rst = 1'b1;
        #1;
        check("async_rst_grant", 32'(o_grant), 32'd0);
        check("async_rst_tx_valid", 32'(o_tx_valid), 32'd0);
        for (int k = 0; k < N_REQ; k++) src_q[k].delete();
        exp_q.delete();
        push_pkt(0, 8'h05, 1'b1);
        push_pkt(3, 8'h35, 1'b1);
        drive_inputs();
        @(posedge clk);
        #1 rst = 1'b0;
        step(); check("post_rst_arb_cycle", 32'(last_grant), 32'd0);
        step(); check("post_rst_first_grant", 32'(last_grant), 32'b0001);
        run_until_empty("post_rst", 20);

        // Non-owner isolation
        do_reset();
        rdy_mode = 1;
        for (int i = 0; i < 6; i++) push_pkt(0, 8'(8'hC0 + i), 1'(i == 5));
        noise_en[1] = 1'b1;
        drive_inputs();
        n = 0; bad = 0;
        while (!(exp_q.size() == 0 && srcs_empty()) && n < 200) begin
            step();
            n++;
            if (last_ready[1] || (last_txvalid && last_txdata == 8'hFF)) bad++;
        end
        check("isolation_bad_cycles", 32'(bad), 32'd0);
        noise_en[1] = 1'b0;
        run_until_empty("isolation", 20);

        // Randomised rounds of whole packets, pointer carried across rounds
        do_reset();
        gaps_on  = 1'b1;
        rdy_mode = 1;
        repeat (4) begin
            for (int k = 0; k < N_REQ; k++) begin
                npk = int'($urandom_range(0, 3));
                for (int p = 0; p < npk; p++) begin
                    len = int'($urandom_range(1, 4));
                    for (int b = 0; b < len; b++)
                        src_q[k].push_back('{8'($urandom), 1'(b == len - 1)});
                end
            end
            model_round();
            drive_inputs();
            run_until_empty("random", 3000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single SoC UART transmitter between up to N_REQ byte-stream requesters (CPU MMIO store path, boot-loader echo, debug/trace unit, ...). Round-robin arbitration at packet granularity: a grant is held until the owner sends a byte flagged last, or until an idle-timeout watchdog reclaims the channel. Sits between the requesters and the UART TX serializer's valid/ready byte interface, inside system.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width forwarded to the serializer
TIMEOUT, 12500, cycles a granted requester may hold valid low mid-packet before forced release (about 10 bit-times at BAUD_9600 = 1250 clk/bit)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
i_req_valid  input  N_REQ  per-requester byte valid
i_req_data  input  N_REQ*DATA_W  per-requester byte; requester k occupies bits [k*DATA_W +: DATA_W]
i_req_last  input  N_REQ  byte is final byte of packet
o_req_ready  output  N_REQ  per-requester accept; only the granted bit can be high
o_tx_valid  output  1  byte valid to serializer
o_tx_data  output  DATA_W  byte to serializer
i_tx_ready  input  1  serializer can accept byte this cycle
o_grant  output  N_REQ  one-hot current owner; all zero when idle
o_timeout  output  1  one-cycle pulse on watchdog release

Behaviour:
- Reset (async, rst=1): state IDLE, o_grant=0, rr pointer=N_REQ-1 (requester 0 wins first), timeout counter=0, o_timeout=0. While idle, o_tx_valid=0, o_req_ready=0 and o_tx_data=0.
- FSM states IDLE, OWN.
- IDLE: if any i_req_valid high, select the first valid index searching (ptr+1) mod N_REQ upward with wrap. Register o_grant one-hot and move to OWN at the next edge. Grant latency is 1 cycle. No byte is transferred in the arbitration cycle.
- OWN, datapath is combinational from the registered grant:
  - o_tx_valid = i_req_valid[g]
  - o_tx_data = i_req_data[g]
  - o_req_ready[g] = i_tx_ready
  - other ready bits are 0
- A transfer occurs on a cycle with i_req_valid[g] & i_tx_ready.
- Transfer with i_req_last[g]=1: at that edge, ptr<=g, o_grant<=0, state<=IDLE. The next grant comes no earlier than 1 cycle later. Back-to-back packets from different requesters therefore have a minimum 1-cycle gap.
- Watchdog:
  - In OWN, the counter increments on every cycle with i_req_valid[g]=0.
  - It clears on any cycle with i_req_valid[g]=1, whether stalled by ready or not.
  - A stall caused by i_tx_ready=0 never times out.
  - When the counter reaches TIMEOUT-1 with valid still low: release to IDLE, ptr<=g, pulse o_timeout for 1 cycle.
  - The counter is cleared on every entry to OWN.
  - The width is clog2(TIMEOUT+1).
- Simultaneous requests: strict rotation; every valid requester is served within N_REQ packets (no starvation).
- Requester drops valid without last: channel stays locked until valid returns or timeout.
- i_req_last is ignored unless the transfer actually occurs.
- No data buffering. The arbiter never holds a byte, so reset mid-packet loses nothing held internally. The serializer's in-flight byte is its own concern.
- o_grant is always zero or one-hot (assertion).

Decomposition:
- Shared package uart_pkg:
  - BAUD_9600=1250
  - UART_DATA_W=8
  - state enum {ARB_IDLE, ARB_OWN}
  - helper function for rotating priority select
- One natural sub-module: rr_pick. Combinational rotating-priority encoder with inputs req[N_REQ] and ptr, and outputs onehot[N_REQ], idx and any. It is reused by future bus arbiters.
- FSM, watchdog and mux stay in uart_tx_arbiter.

Test Plan:
- Single requester: req1 sends 0x61 then 0x62 (last), i_tx_ready=1 → o_grant=0010 one cycle after valid; o_tx_data 0x61, 0x62 on consecutive cycles; o_grant=0 the cycle after 0x62.
- Contention after reset: req0, req2, req3 all valid with 1-byte packets (last=1) → service order 0, 2, 3. Then a re-request from all three → order 0, 2, 3 again (ptr wraps from 3).
- Backpressure: i_tx_ready low for 5000 cycles while req2 holds valid with 0x41 → o_tx_data stable 0x41, o_req_ready[2]=0, no o_timeout. Byte accepted on the first ready cycle.
- Timeout: req1 sends 0x10 (not last), then drops valid → o_timeout pulses exactly TIMEOUT cycles later, o_grant=0. A pending req2 is granted on the following cycle.
- Reset mid-packet: assert rst while req3 is owner mid-packet → o_grant=0, o_tx_valid=0 immediately (async). After release, pending req0 and req3 → req0 granted first.
- Non-owner isolation: req0 owns and req1 toggles valid/last with 0xFF → o_req_ready[1]=0 throughout and 0xFF never appears on o_tx_data.
